// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Purpose  : CH-channel programmable strobe generator. Each channel divides
//            clk by a runtime-loadable divisor and emits a one-cycle tick.
//            New divisors are shadowed and take effect only at a period
//            boundary. The optional ~50% duty level output is built only when
//            the macro CLK_DIV_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter  int CH          = 2,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en_i,
    input  logic             sync_i,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [CH-1:0]    pend_o,
    output logic [CH-1:0]    tick_o,
    output logic [CH-1:0]    level_o
);

    localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [31:0]      C_CH          = 32'(CH);

    logic [31:0] w_cfg_ch_ext;
    logic        w_cfg_valid;

    assign w_cfg_ch_ext = 32'(cfg_ch);
    assign w_cfg_valid  = cfg_we && (w_cfg_ch_ext < C_CH);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] active_q, active_d;
        logic [CNT_W-1:0] shadow_q, shadow_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] w_div_eff;
        logic [CNT_W-1:0] w_new_div;
        logic             w_hit;
        logic             w_wrap;
        logic             w_pend_any;

        assign w_hit      = w_cfg_valid && (cfg_ch == CH_W'(i));
        // A stored divisor of 0 runs as divide-by-1.
        assign w_div_eff  = (active_q == '0) ? CNT_W'(1) : active_q;
        assign w_wrap     = (cnt_q >= (w_div_eff - CNT_W'(1)));
        // A write landing on the boundary cycle is applied at that boundary.
        assign w_new_div  = w_hit ? cfg_div : shadow_q;
        assign w_pend_any = w_hit | pend_q;

        always_comb begin
            cnt_d    = cnt_q;
            active_d = active_q;
            shadow_d = w_new_div;
            pend_d   = w_pend_any;
            tick_d   = en_i[i] & w_wrap;
            if (!en_i[i] || sync_i || w_wrap) begin
                cnt_d = '0;
                if (w_pend_any) begin
                    active_d = w_new_div;
                    pend_d   = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                active_q <= C_DEFAULT_DIV;
                shadow_q <= C_DEFAULT_DIV;
                pend_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                active_q <= active_d;
                shadow_q <= shadow_d;
                pend_q   <= pend_d;
                tick_q   <= tick_d;
            end
        end

        assign pend_o[i] = pend_q;
        assign tick_o[i] = tick_q;

`ifdef CLK_DIV_LEVEL_EN
        logic             level_q, level_d;
        logic [CNT_W:0]   w_half;

        // High for ceil(d/2) cycles, restarted by each tick; sync or disable
        // drop it until the next tick so the duty phase matches the ticks.
        assign w_half  = ({1'b0, w_div_eff} + (CNT_W+1)'(1)) >> 1;
        assign level_d = tick_d |
                         (level_q & en_i[i] & ~sync_i & ({1'b0, cnt_d} < w_half));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q <= 1'b0;
            end else begin
                level_q <= level_d;
            end
        end

        assign level_o[i] = level_q;
`endif
    end

`ifndef CLK_DIV_LEVEL_EN
    assign level_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Purpose  : Scoreboard bench for clk_div_multi (CH=3, DEFAULT_DIV=2);
//            expected per-cycle output bits are queued by the stimulus and
//            consumed by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int CH    = 3;
    localparam int CNT_W = 16;
    localparam int K_TICK = 0;
    localparam int K_PEND = 1;
    localparam int K_LVL  = 2;

`ifdef CLK_DIV_LEVEL_EN
    localparam string LVL_A  = "01010101";
    localparam string LVL_F1 = "000011100111";
    localparam string LVL_F2 = "00111111";
`else
    localparam string LVL_A  = "00000000";
    localparam string LVL_F1 = "000000000000";
    localparam string LVL_F2 = "00000000";
`endif

    logic             clk;
    logic             rst;
    logic [CH-1:0]    en_i;
    logic             sync_i;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CH-1:0]    pend_o;
    logic [CH-1:0]    tick_o;
    logic [CH-1:0]    level_o;

    clk_div_multi #(.CH(CH), .CNT_W(CNT_W), .DEFAULT_DIV(2)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .sync_i  (sync_i),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .pend_o  (pend_o),
        .tick_o  (tick_o),
        .level_o (level_o)
    );

    typedef struct {
        int    cyc;
        int    ch;
        int    kind;
        bit    val;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: consume every expectation stamped for the current cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                logic act;
                case (sb[k].kind)
                    K_TICK:  act = tick_o[sb[k].ch];
                    K_PEND:  act = pend_o[sb[k].ch];
                    default: act = level_o[sb[k].ch];
                endcase
                n_checks++;
                if (act === sb[k].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s ch%0d cyc%0d: got %0b want %0b",
                             sb[k].nm, sb[k].ch, cyc, act, sb[k].val);
                end
                sb.delete(k);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pat[j] is the expected bit at cycle (now + start + j).
    task automatic push_pat(input int ch, input int kind, input int start,
                            input string pat, input string nm);
        for (int j = 0; j < pat.len(); j++) begin
            exp_t e;
            e.cyc  = cyc + start + j;
            e.ch   = ch;
            e.kind = kind;
            e.val  = (pat[j] == "1");
            e.nm   = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wr(input int ch, input int div);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = CNT_W'(div);
    endtask

    initial begin
        rst = 1'b1; en_i = '0; sync_i = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        step(3);
        n_checks++;
        if (tick_o === 3'b000) n_pass++;
        else $display("FAIL in_rst_tick: got %b want 000", tick_o);
        n_checks++;
        if (pend_o === 3'b000) n_pass++;
        else $display("FAIL in_rst_pend: got %b want 000", pend_o);
        n_checks++;
        if (level_o === 3'b000) n_pass++;
        else $display("FAIL in_rst_level: got %b want 000", level_o);
        for (int c = 0; c < CH; c++) begin
            push_pat(c, K_TICK, 0, "0", "rst_tick");
            push_pat(c, K_PEND, 0, "0", "rst_pend");
            push_pat(c, K_LVL,  0, "0", "rst_level");
        end
        rst = 1'b0;

        // Default divisor 2 on ch0
        en_i = 3'b001;
        push_pat(0, K_TICK, 1, "01010101", "a_tick");
        push_pat(0, K_PEND, 1, "00000000", "a_pend");
        push_pat(0, K_LVL,  1, LVL_A,      "a_level");
        step(8);

        // ch1 at d=3, then a mid-period write of 5
        en_i = 3'b000;
        wr(1, 3);
        push_pat(1, K_PEND, 1, "0", "b_dis_apply_pend");
        step(1);
        cfg_we = 1'b0;
        en_i = 3'b010;
        push_pat(1, K_TICK, 1, "0010", "b_tick_d3");
        push_pat(0, K_TICK, 1, "0000", "b_ch0_idle");
        step(4);
        wr(1, 5);
        push_pat(1, K_TICK, 1, "010000100001", "b_tick_d5");
        push_pat(1, K_PEND, 1, "100000",       "b_pend");
        step(1);
        cfg_we = 1'b0;
        step(11);
        en_i = 3'b000;
        push_pat(1, K_TICK, 1, "0", "b_dis_tick");
        step(1);

        // ch0: divisor 0 behaves as 1, then a write of 4 on a wrap cycle
        en_i = 3'b001;
        wr(0, 0);
        push_pat(0, K_TICK, 1, "01111111", "c_tick_d0");
        push_pat(0, K_PEND, 1, "10000000", "c_pend_d0");
        step(1);
        cfg_we = 1'b0;
        step(7);
        wr(0, 4);
        push_pat(0, K_TICK, 1, "100010001", "c_tick_d4");
        push_pat(0, K_PEND, 1, "000",       "c_bypass_pend");
        step(1);
        cfg_we = 1'b0;
        step(8);

        // Sync with ch0 d=4 at terminal count and ch1 d=6 mid-period
        wr(1, 6);
        step(1);
        cfg_we = 1'b0;
        en_i = 3'b011;
        step(2);
        sync_i = 1'b1;
        push_pat(0, K_TICK, 1, "1000100010001", "d_sync_tick0");
        push_pat(1, K_TICK, 1, "0000001000001", "d_sync_tick1");
        step(1);
        sync_i = 1'b0;
        step(12);

        // Reset while an update is pending
        wr(0, 7);
        push_pat(0, K_PEND, 1, "1", "e_pend_before_rst");
        step(1);
        cfg_we = 1'b0;
        step(1);
        rst = 1'b1;
        for (int c = 0; c < CH; c++) begin
            push_pat(c, K_PEND, 0, "0", "e_rst_pend");
            push_pat(c, K_TICK, 0, "0", "e_rst_tick");
        end
        step(2);
        rst = 1'b0;
        wr(3, 9);
        push_pat(0, K_TICK, 1, "010101", "e_tick0_default");
        push_pat(1, K_TICK, 1, "010101", "e_tick1_default");
        push_pat(2, K_TICK, 1, "000000", "e_tick2_idle");
        for (int c = 0; c < CH; c++) begin
            push_pat(c, K_PEND, 1, "000000", "e_bad_ch_pend");
        end
        step(1);
        cfg_we = 1'b0;
        step(5);

        // d=5 level shape, then d=1
        en_i = 3'b000;
        wr(0, 5);
        step(1);
        cfg_we = 1'b0;
        en_i = 3'b001;
        push_pat(0, K_TICK, 1, "000010000100", "f_tick_d5");
        push_pat(0, K_LVL,  1, LVL_F1,         "f_level_d5");
        step(12);
        wr(0, 1);
        push_pat(0, K_TICK, 1, "00111111", "f_tick_d1");
        push_pat(0, K_LVL,  1, LVL_F2,     "f_level_d1");
        push_pat(0, K_PEND, 1, "110",      "f_pend_d1");
        step(1);
        cfg_we = 1'b0;
        step(7);
        en_i = 3'b000;
        push_pat(0, K_TICK, 1, "0", "f_dis_tick");
        push_pat(0, K_LVL,  1, "0", "f_dis_level");
        step(2);

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        while (sb.size() != 0) begin
            n_checks++;
            $display("FAIL unchecked %s ch%0d cyc%0d: got none want %0b",
                     sb[0].nm, sb[0].ch, sb[0].cyc, sb[0].val);
            sb.delete(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass == n_checks) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable strobe generator; successor to the fixed single-output pixel-clock divider.
- Each of CH channels divides clk by a runtime-loadable divisor and emits a one-cycle strobe (tick_o) per period.
- Divisor updates are glitch-free: a shadow register is applied only at a period boundary.
- Feeds VGA pixel enable, line/frame timing and slower housekeeping strobes from one block.

Parameters:
CH, 2, number of independent channels (>=1)
CNT_W, 16, counter/divisor width in bits
DEFAULT_DIV, 2, active divisor of every channel after reset (1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en_i  in  CH  per-channel enable
sync_i  in  1  phase-align all channels
cfg_we  in  1  divisor write strobe
cfg_ch  in  max(1,$clog2(CH))  target channel of write
cfg_div  in  CNT_W  divisor value to write
pend_o  out  CH  per-channel update pending
tick_o  out  CH  per-channel one-cycle strobe, registered
level_o  out  CH  per-channel ~50% duty level, registered (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): cnt=0, active_div=DEFAULT_DIV, shadow=DEFAULT_DIV, pend_o=0, tick_o=0, level_o=0.
- Effective divisor d = max(active_div, 1); cfg_div=0 is stored as-is but behaves as 1.
- Channel enabled, no sync: cnt counts 0..d-1 then wraps to 0.
  - tick_o[i] <= (cnt==d-1), registered, so tick_o is high in the cycle after terminal count.
  - en_i rise with cnt=0 and d=4: tick_o high 4 cycles after en_i rise, then every 4 cycles.
  - d=1: tick_o constant high from the cycle after enable.
- Channel disabled: cnt forced to 0 next cycle; tick_o=0, level_o=0 next cycle.
  - A pending update is applied immediately (active<=shadow, pend<=0).
- Config write:
  - cfg_we with cfg_ch<CH: shadow[cfg_ch]<=cfg_div, pend<=1.
  - cfg_ch>=CH: write ignored, no state change.
  - Back-to-back writes before the boundary: last write wins.
- Apply point: on the wrap cycle (cnt==d-1) with pend=1, active<=shadow, pend<=0; the new period starts at cnt=0.
  - Write in the same cycle as a wrap: the written value is applied at that wrap (bypass); pend stays 0.
- sync_i: every enabled channel gets cnt<=0 next cycle and applies any pending update. No tick is generated by the sync itself.
  - sync_i has priority over the wrap.
  - A tick already due from terminal count in the sync cycle is still emitted.
- Multiple channels are fully independent except for the shared cfg and sync_i inputs.
- Reset mid-period: all state returns to reset values asynchronously; pending writes are lost.

Optional Feature:
- Macro CLK_DIV_LEVEL_EN.
- Defined: level_o[i] registered, high for ceil(d/2) cycles starting with the tick_o cycle and low for the remaining floor(d/2). d=1 gives constant high while enabled. Follows the same enable/sync/apply rules; the period changes only at the boundary.
- Undefined: level_o tied to 0; no level logic synthesised.

Test Plan:
- Reset, en_i=1 on ch0 with DEFAULT_DIV=2 -> tick_o[0] high every 2nd cycle, first one 2 cycles after enable; pend_o=0.
- Write cfg_ch=1, cfg_div=5 mid-period while ch1 runs at d=3 -> pend_o[1]=1 until the next ch1 wrap, then tick spacing 5; no short or long period in between.
- Write cfg_div=0 to ch0 -> after apply, tick_o[0] constant high; then write 4 -> spacing 4.
- Pulse sync_i with ch0 d=4 and ch1 d=6 at arbitrary phases -> both counters 0 the next cycle; ticks at +4 and +6 cycles from the sync, aligned.
- Assert rst mid-period with pend_o=1 -> all outputs 0 immediately; after release, d=DEFAULT_DIV and pend_o=0. Write with cfg_ch=CH -> no effect.
- With CLK_DIV_LEVEL_EN defined, d=5 -> level_o high 3 cycles, low 2 cycles, rising with tick_o; d=1 -> level_o constantly high.
